uart_alu_bridge: RTL

UART_ALU_BRIDGE -- requirements
Module: uart_alu_bridge

---
 rtl/uart_alu_if.sv | 23 ++
 rtl/uart_alu_bridge.sv | 113 +++++++++++
 2 files changed

// File: rtl/uart_alu_if.sv
// Byte-stream handshake between the UART FIFOs and the ALU bridge.
// "master" is the bridge side, "slave" is the FIFO side.
interface uart_alu_if #(
  parameter int unsigned DBIT = 8
) ();
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            tx_full;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic            op_err;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, wr_uart, w_data, op_err
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, wr_uart, w_data, op_err
  );
endinterface

// File: rtl/uart_alu_bridge.sv
// Reads A, B and an opcode byte from the receive FIFO, executes one ALU
// operation and pushes the result byte to the transmit FIFO.
module uart_alu_bridge #(
  parameter int unsigned DBIT  = 8,
  parameter int unsigned NB_OP = 6
) (
  input  logic      clk,
  input  logic      reset,
  uart_alu_if.master bus
);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  state_t            state_q, state_d;
  logic [DBIT-1:0]   a_q, b_q, w_data_q;
  logic [NB_OP-1:0]  op_q;
  logic              op_err_q;
  logic              rd_c, wr_c;
  logic              ld_a, ld_b, ld_op, ld_res;
  logic [DBIT-1:0]   res_c;
  logic              err_c;
  logic              shamt_big_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= GET_A;
    else        state_q <= state_d;
  end

  // Next state, FIFO strobes and load enables
  always_comb begin
    state_d = state_q;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    ld_res  = 1'b0;
    case (state_q)
      GET_A: if (!bus.rx_empty) begin
        rd_c = 1'b1; ld_a = 1'b1; state_d = GET_B;
      end
      GET_B: if (!bus.rx_empty) begin
        rd_c = 1'b1; ld_b = 1'b1; state_d = GET_OP;
      end
      GET_OP: if (!bus.rx_empty) begin
        rd_c = 1'b1; ld_op = 1'b1; state_d = EXEC;
      end
      EXEC: begin
        ld_res  = 1'b1;
        state_d = SEND;
      end
      SEND: if (!bus.tx_full) begin
        wr_c = 1'b1; state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase
  end

  // Shift amounts of DBIT or more saturate to the full-width fill value
  assign shamt_big_c = (32'(b_q) >= DBIT);

  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (op_q)
      OP_ADD: res_c = a_q + b_q;
      OP_SUB: res_c = a_q - b_q;
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_XOR: res_c = a_q ^ b_q;
      OP_NOR: res_c = ~(a_q | b_q);
      OP_SRA: res_c = shamt_big_c ? {DBIT{a_q[DBIT-1]}} : $unsigned($signed(a_q) >>> b_q);
      OP_SRL: res_c = shamt_big_c ? '0 : (a_q >> b_q);
      default: err_c = 1'b1;
    endcase
  end

  // Operand capture and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      w_data_q <= '0;
      op_err_q <= 1'b0;
    end else begin
      if (ld_a)  a_q  <= bus.r_data;
      if (ld_b)  b_q  <= bus.r_data;
      if (ld_op) op_q <= bus.r_data[NB_OP-1:0];
      if (ld_res) begin
        w_data_q <= res_c;
        op_err_q <= err_c;
      end
    end
  end

  // Strobes are masked while reset is held so no FIFO access leaks through
  assign bus.rd_uart = rd_c & reset;
  assign bus.wr_uart = wr_c & reset;
  assign bus.w_data  = w_data_q;
  assign bus.op_err  = op_err_q;

endmodule
